dm_access_unit: RTL and testbench
=================================

# dm_access_unit

MEM-stage data-memory access unit for the pipelined RV32I core. It consumes the memory controls produced by the decoder: mem_read, mem_write and the 3-bit DMType. It runs a single-outstanding request/acknowledge transaction on the data bus, generating byte enables and lane-replicated store data, and returns sign- or zero-extended load data. It stalls the pipeline until the access completes.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, bus data width; only 32 is supported

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage holds a valid instruction
- mem_read  in  1  load
- mem_write  in  1  store; wins if mem_read is also set
- dm_type  in  3  000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned; 101–111 treated as word
- addr  in  ADDR_W  byte address from the ALU
- wdata  in  32  store source (rs2)
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- rdata  out  32  formatted load result
- rdata_valid  out  1  one-cycle pulse; rdata is valid
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address, bits [1:0] = 00
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  completion; read data is valid in the same cycle
- bus_rdata  in  32  read word
- misalign  out  1  one-cycle pulse (only with DM_MISALIGN_TRAP_EN)

## Operation
- FSM states are IDLE, BUS and DONE.
- **IDLE.** If req_valid & (mem_read|mem_write): assert stall combinationally, latch the operation, and go to BUS.
- **BUS.** bus_req=1 and all bus_* outputs are held stable until bus_ack. On ack, loads capture bus_rdata, then go to DONE.
- **DONE.** stall=0, so the pipeline advances at this edge. rdata_valid=1 for loads. req_valid is ignored here because it is the same instruction. Next state is IDLE.
- **Byte enables by access type:**
  - Word: be=1111.
  - Half: be = addr[1] ? 1100 : 0011.
  - Byte: be = 0001 << addr[1:0].
- **Store data.** Byte stores replicate wdata[7:0] to all four lanes; half stores replicate wdata[15:0] to both halves.
- **Load formatting.** Select the lane by addr[1:0] (byte) or addr[1] (half). Sign-extend for 011/001; zero-extend for 100/010.
- bus_ack outside BUS is ignored.

## Timing
- **Reset values:** state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rdata=0, rdata_valid=0, misalign=0. stall=0 after reset.
- **Bus outputs are registered.** bus_req rises the cycle after acceptance.
- **Occupancy** is 3 cycles for an ack in the first BUS cycle, and 2+N cycles for N BUS cycles.
- **Back-to-back accesses.** A new access is accepted in the first IDLE cycle after DONE; there are no idle bubbles beyond that.
- **rst mid-transaction.** Return to IDLE and drop bus_req at the next edge. A late ack is ignored. No rdata_valid is produced.
- **Neither mem_read nor mem_write set.** stall stays 0 and the unit stays in IDLE.

## Configuration
- DM_MISALIGN_TRAP_EN is the single feature switch.
- **Defined.** A half access with addr[0]=1, or a word access with addr[1:0]≠00, issues no bus request. The FSM goes IDLE→DONE. misalign=1 in DONE. rdata_valid=0, and memory is unchanged.
- **Undefined.** The misalign port is tied to 0. Offending low address bits are ignored:
  - Word accesses use an offset of 00.
  - Half accesses use addr[1] only.

## Structure
- Package dm_pkg holds:
  - DMType localparams DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U.
  - The FSM state enum.
  - The byte-enable constants.
- Sub-module dm_load_fmt is a combinational lane extractor and sign/zero extender. Inputs: bus_rdata, offset[1:0], dm_type.

## Test plan
- lw from 0x100, bus_rdata=0xDEADBEEF, ack in first BUS cycle -> bus_be=1111, rdata=0xDEADBEEF, rdata_valid in cycle 3, stall high for cycles 1–2.
- lb from 0x103, bus_rdata=0x80FF_1234 -> rdata=0xFFFFFF80. lbu from the same address -> rdata=0x00000080.
- sh to 0x202, wdata=0x0000ABCD -> bus_we=1, bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD.
- sb to 0x301 with ack delayed 4 cycles -> all bus_* outputs stable throughout, stall held, exactly one DONE.
- rst asserted in BUS, then bus_ack pulses -> bus_req=0 after the edge, no rdata_valid, next lw completes normally.
- With DM_MISALIGN_TRAP_EN, lw from 0x102 -> no bus_req, misalign pulse, rdata_valid=0. Without the macro -> bus_addr=0x100, be=1111.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - access types, FSM states and byte-enable constants for dm_access_unit
package dm_pkg;

   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } dm_state_e;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_HALF = 2'd1,
      SZ_BYTE = 2'd2
   } dm_size_e;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   // Encodings 101-111 fall through to word.
   function automatic dm_size_e dm_size(input logic [2:0] t);
      case (t)
         DM_HALF, DM_HALF_U: dm_size = SZ_HALF;
         DM_BYTE, DM_BYTE_U: dm_size = SZ_BYTE;
         default:            dm_size = SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/dm_load_fmt.sv
// rtl/dm_load_fmt.sv - load lane extractor with sign/zero extension
module dm_load_fmt
   import dm_pkg::*;
(
   input  logic [31:0] bus_rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  dm_type,
   output logic [31:0] load_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (offset)
         2'd0:    byte_lane = bus_rdata[7:0];
         2'd1:    byte_lane = bus_rdata[15:8];
         2'd2:    byte_lane = bus_rdata[23:16];
         default: byte_lane = bus_rdata[31:24];
      endcase
      half_lane = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (dm_type)
         DM_BYTE:   load_data = {{24{byte_lane[7]}}, byte_lane};
         DM_BYTE_U: load_data = {24'b0, byte_lane};
         DM_HALF:   load_data = {{16{half_lane[15]}}, half_lane};
         DM_HALF_U: load_data = {16'b0, half_lane};
         default:   load_data = bus_rdata;
      endcase
   end

endmodule

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - MEM-stage data-memory access unit; optional DM_MISALIGN_TRAP_EN
module dm_access_unit
   import dm_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        dm_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              misalign
);

   dm_state_e         state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rdata_valid_q, rdata_valid_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        type_q, type_d;

   logic              accept;
   logic              trap;
   dm_size_e          size;
   logic [1:0]        eff_off;
   logic [3:0]        be_new;
   logic [31:0]       wdata_new;
   logic [31:0]       load_data;

   assign accept = req_valid && (mem_read || mem_write);
   assign size   = dm_size(dm_type);

`ifdef DM_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;
   assign trap     = ((size == SZ_HALF) && addr[0]) ||
                     ((size == SZ_WORD) && (addr[1:0] != 2'b00));
   assign misalign = misalign_q;
`else
   assign trap     = 1'b0;
   assign misalign = 1'b0;
`endif

   // Low address bits below the access size are dropped when not trapping.
   always_comb begin
      case (size)
         SZ_HALF: begin
            eff_off   = {addr[1], 1'b0};
            be_new    = addr[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_new = {2{wdata[15:0]}};
         end
         SZ_BYTE: begin
            eff_off   = addr[1:0];
            be_new    = BE_BYTE0 << addr[1:0];
            wdata_new = {4{wdata[7:0]}};
         end
         default: begin
            eff_off   = 2'b00;
            be_new    = BE_WORD;
            wdata_new = wdata;
         end
      endcase
   end

   dm_load_fmt u_load_fmt (
      .bus_rdata (bus_rdata),
      .offset    (off_q),
      .dm_type   (type_q),
      .load_data (load_data)
   );

   always_comb begin
      state_d       = state_q;
      bus_req_d     = bus_req_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_be_d      = bus_be_q;
      bus_wdata_d   = bus_wdata_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      off_d         = off_q;
      type_d        = type_q;
`ifdef DM_MISALIGN_TRAP_EN
      misalign_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               off_d  = eff_off;
               type_d = dm_type;
               if (trap) begin
                  state_d = ST_DONE;
`ifdef DM_MISALIGN_TRAP_EN
                  misalign_d = 1'b1;
`endif
               end else begin
                  state_d     = ST_BUS;
                  bus_req_d   = 1'b1;
                  bus_we_d    = mem_write;
                  bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  bus_be_d    = be_new;
                  bus_wdata_d = wdata_new;
               end
            end
         end
         ST_BUS: begin
            if (bus_ack) begin
               state_d   = ST_DONE;
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               if (!bus_we_q) begin
                  rdata_d       = load_data;
                  rdata_valid_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_be_q      <= 4'b0;
         bus_wdata_q   <= 32'b0;
         rdata_q       <= 32'b0;
         rdata_valid_q <= 1'b0;
         off_q         <= 2'b0;
         type_q        <= 3'b0;
`ifdef DM_MISALIGN_TRAP_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_be_q      <= bus_be_d;
         bus_wdata_q   <= bus_wdata_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         off_q         <= off_d;
         type_q        <= type_d;
`ifdef DM_MISALIGN_TRAP_EN
         misalign_q    <= misalign_d;
`endif
      end
   end

   // DONE deliberately drops stall even if req_valid is still high.
   assign stall       = ((state_q == ST_IDLE) && accept) || (state_q == ST_BUS);
   assign bus_req     = bus_req_q;
   assign bus_we      = bus_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_be      = bus_be_q;
   assign bus_wdata   = bus_wdata_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - self-checking bench for dm_access_unit
module tb_dm_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, mem_read, mem_write;
   logic [2:0]  dm_type;
   logic [31:0] addr, wdata;
   logic        stall, rdata_valid, bus_req, bus_we, bus_ack, misalign;
   logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int n_checks = 0;
   int n_err    = 0;

   logic        chk_en = 1'b0;
   logic        exp_stall, exp_req, exp_we, exp_rvalid, exp_mis;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [3:0]  exp_be;

   int          n_stall, n_req, n_rvalid, n_mis;
   logic [31:0] snap_rdata, snap_addr, snap_wdata;
   logic [3:0]  snap_be;
   logic        snap_we;

   dm_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .dm_type     (dm_type),
      .addr        (addr),
      .wdata       (wdata),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_be      (bus_be),
      .bus_wdata   (bus_wdata),
      .bus_ack     (bus_ack),
      .bus_rdata   (bus_rdata),
      .misalign    (misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: access size in bytes, offset aligned down to that size.
   function automatic int m_nbytes(input logic [2:0] t);
      if (t == 3'd1 || t == 3'd2) return 2;
      if (t == 3'd3 || t == 3'd4) return 1;
      return 4;
   endfunction

   function automatic int m_off(input logic [2:0] t, input logic [31:0] a);
      int n = m_nbytes(t);
      return (int'(a % 4) / n) * n;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
      int n = m_nbytes(t);
      return 4'(((1 << n) - 1) << m_off(t, a));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] w);
      int n = m_nbytes(t);
      if (n == 1) return (w & 32'hFF) * 32'h01010101;
      if (n == 2) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] r);
      int          n = m_nbytes(t);
      logic [31:0] v, mask;
      v = r >> (8 * m_off(t, a));
      if (n == 4) return v;
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if ((t == 3'd1 || t == 3'd3) && v >= (32'd1 << (8 * n - 1))) v = v | ~mask;
      return v;
   endfunction

   function automatic bit m_misaligned(input logic [2:0] t, input logic [31:0] a);
      return (a % m_nbytes(t)) != 0;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", 32'(stall), 32'(exp_stall));
         check("bus_req", 32'(bus_req), 32'(exp_req));
         check("rdata_valid", 32'(rdata_valid), 32'(exp_rvalid));
         check("misalign", 32'(misalign), 32'(exp_mis));
         if (exp_req) begin
            check("bus_we", 32'(bus_we), 32'(exp_we));
            check("bus_addr", bus_addr, exp_addr);
            check("bus_be", 32'(bus_be), 32'(exp_be));
            check("bus_wdata", bus_wdata, exp_wdata);
         end
         if (exp_rvalid) check("rdata", rdata, exp_rdata);
         if (stall) n_stall++;
         if (misalign) n_mis++;
         if (bus_req) begin
            n_req++;
            snap_addr  = bus_addr;
            snap_be    = bus_be;
            snap_wdata = bus_wdata;
            snap_we    = bus_we;
         end
         if (rdata_valid) begin
            n_rvalid++;
            snap_rdata = rdata;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      n_stall = 0; n_req = 0; n_rvalid = 0; n_mis = 0;
   endtask

   task automatic exp_idle();
      exp_stall = 1'b0; exp_req = 1'b0; exp_rvalid = 1'b0; exp_mis = 1'b0;
   endtask

   task automatic idle(input int cycles, input logic stray_ack);
      req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         bus_ack = stray_ack && (i == 0);
         exp_idle();
         tick();
      end
      bus_ack = 1'b0;
   endtask

   // Drives one access starting now; returns right after the DONE cycle.
   task automatic access(input logic rd, input logic wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] rdat, input int delay);
      req_valid = 1'b1; mem_read = rd; mem_write = wr; dm_type = t; addr = a; wdata = w;
      bus_ack = 1'b0; bus_rdata = 32'h5A5A5A5A;
      exp_idle();
      exp_stall = 1'b1;
      tick();
`ifdef DM_MISALIGN_TRAP_EN
      if (m_misaligned(t, a)) begin
         exp_idle();
         exp_mis = 1'b1;
         tick();
         return;
      end
`endif
      for (int k = 0; k <= delay; k++) begin
         exp_stall = 1'b1; exp_req = 1'b1; exp_rvalid = 1'b0; exp_mis = 1'b0;
         exp_we = wr; exp_addr = a & 32'hFFFFFFFC;
         exp_be = m_be(t, a); exp_wdata = m_wdata(t, w);
         bus_ack   = (k == delay);
         bus_rdata = (k == delay) ? rdat : 32'h5A5A5A5A;
         tick();
      end
      bus_ack = 1'b0; bus_rdata = 32'h0;
      exp_idle();
      exp_rvalid = !wr;
      exp_rdata  = m_load(t, a, rdat);
      tick();
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      dm_type = 3'd0; addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      exp_idle();
      exp_we = 1'b0; exp_addr = 0; exp_wdata = 0; exp_rdata = 0; exp_be = 0;
      clr_stats();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_stall", 32'(stall), 32'd0);
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_bus_we", 32'(bus_we), 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_be", 32'(bus_be), 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);

      chk_en = 1'b1;
      idle(2, 1'b0);

      // lw 0x100, ack in first BUS cycle
      clr_stats();
      access(1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      idle(1, 1'b0);
      check("lw_rdata", snap_rdata, 32'hDEADBEEF);
      check("lw_be", 32'(snap_be), 32'hF);
      check("lw_stall_cycles", n_stall, 2);
      check("lw_rvalid_count", n_rvalid, 1);

      // lb then lbu back-to-back
      access(1'b1, 1'b0, 3'd3, 32'h103, 32'h0, 32'h80FF1234, 0);
      check("lb_rdata", snap_rdata, 32'hFFFFFF80);
      access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 0);
      check("lbu_rdata", snap_rdata, 32'h00000080);

      // sh to 0x202
      clr_stats();
      access(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 0);
      check("sh_we", 32'(snap_we), 32'd1);
      check("sh_addr", snap_addr, 32'h200);
      check("sh_be", 32'(snap_be), 32'hC);
      check("sh_wdata", snap_wdata, 32'hABCDABCD);
      check("sh_rvalid_count", n_rvalid, 0);

      // sb to 0x301, ack after 4 extra BUS cycles
      clr_stats();
      access(1'b0, 1'b1, 3'd3, 32'h301, 32'h000000E7, 32'h0, 4);
      idle(2, 1'b0);
      check("sb_stall_cycles", n_stall, 6);
      check("sb_req_cycles", n_req, 5);
      check("sb_be", 32'(snap_be), 32'h2);
      check("sb_wdata", snap_wdata, 32'hE7E7E7E7);

      // halves, store-wins, alternate word encoding, stray ack, no-op request
      access(1'b1, 1'b0, 3'd1, 32'h106, 32'h0, 32'h80017FFF, 2);
      check("lh_rdata", snap_rdata, 32'hFFFF8001);
      access(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 32'h80017FFF, 1);
      check("lhu_rdata", snap_rdata, 32'h00007FFF);
      access(1'b0, 1'b1, 3'd0, 32'h40C, 32'h12345678, 32'h0, 1);
      access(1'b1, 1'b1, 3'd3, 32'h12, 32'h000000A5, 32'hFFFFFFFF, 0);
      check("store_wins_we", 32'(snap_we), 32'd1);
      access(1'b1, 1'b0, 3'd7, 32'h20, 32'h0, 32'hCAFEF00D, 0);
      check("type7_word", snap_rdata, 32'hCAFEF00D);
      idle(2, 1'b1);
      req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      exp_idle();
      tick(); tick();

      // reset while in BUS, then a late ack
      clr_stats();
      req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; dm_type = 3'd0; addr = 32'h80;
      exp_idle(); exp_stall = 1'b1;
      tick();
      exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h80;
      exp_be = 4'hF; exp_wdata = 32'h0;
      rst = 1'b1;
      tick();
      rst = 1'b0; req_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h77777777;
      exp_idle();
      tick();
      bus_ack = 1'b0;
      tick();
      check("rst_mid_rvalid_count", n_rvalid, 0);
      access(1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'h13579BDF, 0);
      check("after_rst_lw", snap_rdata, 32'h13579BDF);

      // misaligned word load
      clr_stats();
      access(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 32'h11223344, 0);
      idle(1, 1'b0);
`ifdef DM_MISALIGN_TRAP_EN
      check("mis_req_cycles", n_req, 0);
      check("mis_pulse_count", n_mis, 1);
      check("mis_rvalid_count", n_rvalid, 0);
`else
      check("mis_addr", snap_addr, 32'h100);
      check("mis_be", 32'(snap_be), 32'hF);
      check("mis_rdata", snap_rdata, 32'h11223344);
`endif
      access(1'b0, 1'b1, 3'd1, 32'h201, 32'h0000BEEF, 32'h0, 0);
      idle(2, 1'b0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
